// File: rtl/cmp_pkg.sv
// Shared types and helpers for the time-shared comparator arbiter.
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        COMPARE = 2'b01,
        RESPOND = 2'b10
    } state_t;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_CNT_W = 16;
    localparam int unsigned MAX_REQ   = 8;

    // First asserted valid at or above ptr, wrapping modulo num_req.
    function automatic int unsigned next_rr(input int unsigned ptr,
                                            input logic [MAX_REQ-1:0] valid,
                                            input int unsigned num_req);
        int unsigned grant;
        int unsigned idx;
        logic [2:0]  idx3;
        logic        found;
        grant = ptr;
        found = 1'b0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            idx  = (ptr + k) % num_req;
            idx3 = 3'(idx);
            if (k < num_req && !found && valid[idx3]) begin
                grant = idx;
                found = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/cmp_ge.sv
// Unsigned magnitude comparator; the single resource shared by all requesters.
module cmp_ge #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ge
);

    assign ge = (a >= b);

endmodule

// File: rtl/cmp_share_arb.sv
// Round-robin arbiter time-sharing one a>=b comparator among NUM_REQ requesters,
// returning ID-tagged results over a valid/ready response channel.
module cmp_share_arb
    import cmp_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned ID_W    = $clog2(NUM_REQ),
    parameter int unsigned CNT_W   = DEF_CNT_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic                     rsp_ge,
    output logic [ID_W-1:0]          rsp_id,
    output logic                     busy,
    input  logic                     cnt_clr,
    output logic [CNT_W-1:0]         op_count
);

    state_t              state, state_nxt;
    logic [ID_W-1:0]     rr_ptr;
    logic [ID_W-1:0]     op_id;
    logic [ID_W-1:0]     grant;
    logic [WIDTH-1:0]    op_a, op_b;
    logic [MAX_REQ-1:0]  valid_ext;
    logic                ge;
    logic                do_grant;
    logic                rsp_hs;

    cmp_ge #(.WIDTH(WIDTH)) u_ge (
        .a  (op_a),
        .b  (op_b),
        .ge (ge)
    );

    always_comb begin
        valid_ext                = '0;
        valid_ext[NUM_REQ-1:0]   = req_valid;
        grant     = ID_W'(next_rr(32'(rr_ptr), valid_ext, NUM_REQ));
        // Gating with rst_n keeps req_ready low for the whole reset interval.
        do_grant  = (state == IDLE) && (|req_valid) && rst_n;
        req_ready = do_grant ? (NUM_REQ'(1) << grant) : '0;
        rsp_hs    = rsp_valid && rsp_ready;
        busy      = (state != IDLE);
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (do_grant) state_nxt = COMPARE;
            COMPARE: state_nxt = RESPOND;
            RESPOND: if (rsp_hs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a  <= '0;
            op_b  <= '0;
            op_id <= '0;
        end else if (do_grant) begin
            op_a  <= req_a[grant*WIDTH +: WIDTH];
            op_b  <= req_b[grant*WIDTH +: WIDTH];
            op_id <= grant;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_ge    <= 1'b0;
            rsp_id    <= '0;
            rr_ptr    <= '0;
        end else if (state == COMPARE) begin
            rsp_valid <= 1'b1;
            rsp_ge    <= ge;
            rsp_id    <= op_id;
        end else if (rsp_hs) begin
            rsp_valid <= 1'b0;
            rr_ptr    <= (op_id == ID_W'(NUM_REQ - 1)) ? '0 : op_id + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count <= '0;
        end else if (cnt_clr) begin
            op_count <= '0;
        end else if (rsp_hs && (op_count != '1)) begin
            op_count <= op_count + 1'b1;
        end
    end

endmodule

// File: doc/cmp_share_arb.md
Name: cmp_share_arb

Overview:
- Time-shares one unsigned magnitude comparator (a >= b) among NUM_REQ requesters.
- Arbitration is round-robin.
- Each requester offers an operand pair over a valid/ready handshake.
- The block registers the pair, evaluates it, and returns the result tagged with the requester ID over a valid/ready response channel. It sits between the requesting datapath units and the shared comparator.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- WIDTH, 8, operand width in bits
- ID_W, $clog2(NUM_REQ), width of requester ID
- CNT_W, 16, width of completed-operation counter

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero
- req_a  in  NUM_REQ*WIDTH  operand a; slice i belongs to requester i
- req_b  in  NUM_REQ*WIDTH  operand b; slice i belongs to requester i
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer accepts result
- rsp_ge  out  1  1 when a >= b (unsigned)
- rsp_id  out  ID_W  index of requester that owns the result
- busy  out  1  high whenever state is not IDLE
- cnt_clr  in  1  synchronous clear of op_count
- op_count  out  CNT_W  completed responses; saturating

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values: state=IDLE, rr_ptr=0, rsp_valid=0, rsp_ge=0, rsp_id=0, op_count=0, busy=0.
- req_ready is 0 while rst_n is low. Deassertion of reset is synchronised by the integrator.
- FSM states are IDLE, COMPARE and RESPOND.
- IDLE:
  - Grant goes to the first i with req_valid[i]=1, searching from rr_ptr upward modulo NUM_REQ.
  - req_ready[grant] is driven combinationally high in that cycle only.
  - On the clock edge: op_a, op_b and op_id capture the granted slice; next state is COMPARE.
  - With no valid request, stay in IDLE with req_ready all zero.
- COMPARE:
  - The comparator sub-module evaluates op_a >= op_b.
  - Result is registered into rsp_ge; op_id goes to rsp_id; rsp_valid is set to 1; next state is RESPOND.
- RESPOND:
  - rsp_valid=1. rsp_ge and rsp_id hold stable until rsp_valid && rsp_ready.
  - On that handshake: rsp_valid goes to 0; rr_ptr becomes (op_id+1) mod NUM_REQ; next state is IDLE.
  - No grants are issued in COMPARE or RESPOND.
- Latency: request handshake at edge T gives rsp_valid high at edge T+2. Minimum period between grants is 3 cycles with rsp_ready tied high.
- Comparison is unsigned over WIDTH bits; equal operands give rsp_ge=1; 0 vs 0 gives 1.
- op_count increments by 1 on each response handshake and saturates at 2^CNT_W-1.
  - cnt_clr=1 forces 0 and takes priority over a simultaneous increment.
- Request-side rules:
  - A requester may drop req_valid before it is granted; nothing is recorded.
  - A requester must hold its operands stable while req_valid=1 and unaccepted.
- Asynchronous reset mid-operation:
  - The in-flight operation is discarded and rsp_valid drops immediately.
  - rr_ptr returns to 0 and no response is ever produced for the discarded request.
- rr_ptr wrap: after a grant to NUM_REQ-1, requester 0 has highest priority.

Decomposition:
- Shared package cmp_pkg holds:
  - the state enum (IDLE, COMPARE, RESPOND), 2-bit encoding;
  - the default WIDTH and CNT_W constants;
  - a function next_rr(ptr, valid) that returns the granted index.
- Sub-module cmp_ge: purely combinational, WIDTH-parameterised unsigned a >= b. It is the shared resource and is instantiated once inside cmp_share_arb.

Test Plan:
- Single requester:
  - Stimulus: reset; req_valid=4'b0001, a=0x80, b=0x7F, rsp_ready=1.
  - Expected: req_ready[0] high one cycle; 2 cycles later rsp_valid=1, rsp_ge=1, rsp_id=0; op_count=1.
- Equality and less-than:
  - Stimulus: requester 2 sends a=0x55, b=0x55, then a=0x00, b=0xFF.
  - Expected: rsp_ge=1 then 0; rsp_id=2 both times.
- Round-robin:
  - Stimulus: all four req_valid held high, rsp_ready=1, for 8 responses.
  - Expected: rsp_id sequence 0,1,2,3,0,1,2,3; every grant spaced exactly 3 cycles apart.
- Backpressure:
  - Stimulus: rsp_ready=0 for 5 cycles after rsp_valid rises, with requester 1 valid meanwhile.
  - Expected: rsp_ge and rsp_id stable; req_ready stays 0; requester 1 is granted only in the cycle after the handshake.
- Async reset mid-op:
  - Stimulus: pull rst_n low while in COMPARE.
  - Expected: rsp_valid=0 and busy=0 immediately; no response emitted after release; next grant starts from requester 0.
- Counter:
  - Stimulus: preload via 65535 handshakes (or force op_count near max), then more handshakes; assert cnt_clr together with a handshake.
  - Expected: op_count stays at 0xFFFF at saturation; it reads 0 after the simultaneous cnt_clr and handshake.
